// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A programmed length of zero is treated as this minimum so every pulse stays a distinct edge.
  localparam int unsigned MIN_PHASE_LEN = 1;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one HIGH or LOW phase; expires in the last cycle of the loaded length.
module phase_timer #(
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_load,
  input  logic [LEN_WIDTH-1:0] in_load_val,
  output logic                 out_expired
);

  logic [LEN_WIDTH-1:0] cnt_q;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      cnt_q <= '0;
    end else if (in_load) begin
      cnt_q <= in_load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign out_expired = (cnt_q == LEN_WIDTH'(1));

endmodule

// File: rtl/pulse_train_generator.sv
// Emits a programmed number of high pulses with programmable high/low lengths on a registered line.
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic                 in_abort,
  input  logic [WIDTH-1:0]     in_count,
  input  logic [LEN_WIDTH-1:0] in_high_len,
  input  logic [LEN_WIDTH-1:0] in_low_len,
  output logic                 out_signal,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [WIDTH-1:0]     out_sent
);

  state_e               state_q, state_nxt;
  logic [WIDTH-1:0]     count_q;
  logic [LEN_WIDTH-1:0] high_len_q, low_len_q;
  logic [LEN_WIDTH-1:0] high_eff, low_eff;
  logic [WIDTH-1:0]     sent_q;
  logic                 timer_load, timer_expired;
  logic [LEN_WIDTH-1:0] timer_val;
  logic                 latch_cfg, sent_clr, sent_inc;
  logic                 last_pulse;

  assign high_eff = (in_high_len == '0) ? LEN_WIDTH'(MIN_PHASE_LEN) : in_high_len;
  assign low_eff  = (in_low_len  == '0) ? LEN_WIDTH'(MIN_PHASE_LEN) : in_low_len;

  // Widened compare so the termination test never depends on sent_q wrapping.
  assign last_pulse = ({1'b0, sent_q} + (WIDTH+1)'(1)) == {1'b0, count_q};

  phase_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_phase_timer (
    .in_clock    (in_clock),
    .in_reset    (in_reset),
    .in_load     (timer_load),
    .in_load_val (timer_val),
    .out_expired (timer_expired)
  );

  always_comb begin
    state_nxt  = state_q;
    timer_load = 1'b0;
    timer_val  = high_len_q;
    latch_cfg  = 1'b0;
    sent_clr   = 1'b0;
    sent_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_start && !in_abort) begin
          latch_cfg = 1'b1;
          sent_clr  = 1'b1;
          if (in_count == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = HIGH;
            timer_load = 1'b1;
            timer_val  = high_eff;
          end
        end
      end
      HIGH: begin
        if (in_abort) begin
          state_nxt = IDLE;
        end else if (timer_expired) begin
          sent_inc = 1'b1;
          if (last_pulse) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = LOW;
            timer_load = 1'b1;
            timer_val  = low_len_q;
          end
        end
      end
      LOW: begin
        if (in_abort) begin
          state_nxt = IDLE;
        end else if (timer_expired) begin
          state_nxt  = HIGH;
          timer_load = 1'b1;
          timer_val  = high_len_q;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      sent_q     <= '0;
      out_signal <= 1'b0;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (latch_cfg) begin
        count_q    <= in_count;
        high_len_q <= high_eff;
        low_len_q  <= low_eff;
      end
      if (sent_clr) begin
        sent_q <= '0;
      end else if (sent_inc) begin
        sent_q <= sent_q + 1'b1;
      end
      // Outputs are decoded from the next state so they align with state_q yet stay flopped.
      out_signal <= (state_nxt == HIGH);
      out_busy   <= (state_nxt == HIGH) || (state_nxt == LOW);
      out_done   <= (state_nxt == DONE);
    end
  end

  assign out_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator with a loopback rising-edge counter.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] count, high_len, low_len;
  logic       sig, busy, done;
  logic [7:0] sent;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned edges = 0;
  int unsigned edge_base;
  logic        sig_prev = 1'b0;

  pulse_train_generator #(
    .WIDTH     (8),
    .LEN_WIDTH (8)
  ) dut (
    .in_clock    (clk),
    .in_reset    (rst_n),
    .in_start    (start),
    .in_abort    (abort),
    .in_count    (count),
    .in_high_len (high_len),
    .in_low_len  (low_len),
    .out_signal  (sig),
    .out_busy    (busy),
    .out_done    (done),
    .out_sent    (sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sig && !sig_prev) edges <= edges + 1;
    sig_prev <= sig;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_train(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    count = c; high_len = h; low_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] pat5;
    logic [6:0] pat7;
    int unsigned n;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    count = '0; high_len = '0; low_len = '0;
    tick(); tick();
    chk("reset_sig", sig, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sent", sent, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of the 2nd pulse of a 5/2/3 train.
    start_train(8'd5, 8'd2, 8'd3);
    chk("mid_first_high", sig, 1);
    repeat (5) tick();
    chk("mid_second_high", sig, 1);
    chk("mid_sent1", sent, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_sig", sig, 0);
    chk("async_drop_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_sig", sig, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_sent", sent, 0);

    // Basic 3/1/1 train.
    edge_base = edges;
    pat5 = 5'b10101;
    start_train(8'd3, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("basic_sig", sig, pat5[4-i]);
      chk("basic_busy", busy, 1);
      chk("basic_nodone", done, 0);
      tick();
    end
    chk("basic_done", done, 1);
    chk("basic_done_sig", sig, 0);
    chk("basic_sent", sent, 3);
    chk("basic_edges", edges - edge_base, 3);
    tick();
    chk("basic_done_onecycle", done, 0);

    // Zero lengths behave as 1/1.
    edge_base = edges;
    pat7 = 7'b1010101;
    start_train(8'd4, 8'd0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      chk("zlen_sig", sig, pat7[6-i]);
      tick();
    end
    chk("zlen_done", done, 1);
    chk("zlen_sent", sent, 4);
    chk("zlen_edges", edges - edge_base, 4);
    tick();

    // Zero count: done next cycle, no edges.
    edge_base = edges;
    start_train(8'd0, 8'd5, 8'd5);
    chk("zcnt_done", done, 1);
    chk("zcnt_sig", sig, 0);
    chk("zcnt_busy", busy, 0);
    chk("zcnt_sent", sent, 0);
    tick();
    chk("zcnt_done_clear", done, 0);
    chk("zcnt_edges", edges - edge_base, 0);

    // Abort during the 4th high phase of a 10/3/2 train.
    start_train(8'd10, 8'd3, 8'd2);
    repeat (16) tick();
    chk("abort_pre_sig", sig, 1);
    chk("abort_pre_sent", sent, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sig", sig, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nodone", done, 0);
    chk("abort_sent", sent, 3);
    tick(); tick();
    chk("abort_nodone_later", done, 0);
    chk("abort_sent_hold", sent, 3);
    // Start together with abort in IDLE is dropped.
    count = 8'd3; high_len = 8'd1; low_len = 8'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", busy, 0);
    chk("startabort_sig", sig, 0);
    chk("startabort_sent", sent, 3);
    tick();
    chk("startabort_nodone", done, 0);

    // Starts while busy and in DONE are ignored.
    start_train(8'd2, 8'd2, 8'd2);
    count = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_t2_sig", sig, 1);
    tick();
    chk("ign_t3_sig", sig, 0);
    tick();
    chk("ign_t4_sig", sig, 0);
    tick();
    chk("ign_t5_sig", sig, 1);
    chk("ign_t5_sent", sent, 1);
    tick();
    chk("ign_t6_sig", sig, 1);
    start = 1'b1;
    tick();
    chk("ign_done", done, 1);
    chk("ign_done_sent", sent, 2);
    tick();
    start = 1'b0;
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_sig", sig, 0);
    chk("ign_idle_done", done, 0);
    chk("ign_idle_sent", sent, 2);
    start_train(8'd1, 8'd1, 8'd1);
    chk("relaunch_sig", sig, 1);
    chk("relaunch_sent_clr", sent, 0);
    tick();
    chk("relaunch_done", done, 1);
    chk("relaunch_sent", sent, 1);
    tick();

    // Max count 255 with 1/1 lengths.
    edge_base = edges;
    start_train(8'd255, 8'd1, 8'd1);
    n = 0;
    while (!done && n < 600) begin
      tick();
      n++;
    end
    chk("max_done_seen", done, 1);
    chk("max_cycles", n, 509);
    chk("max_sent", sent, 255);
    chk("max_edges", edges - edge_base, 255);
    tick();
    chk("max_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
